// File: rtl/dilated_tap_mac_engine_if.sv
// Tap-stream and result handshake bundle for dilated_tap_mac_engine.
// master drives taps/mode/oacts_ready; slave is the engine.
interface dilated_tap_mac_engine_if #(
  parameter int DATA_BITWIDTH  = 8,
  parameter int NUM_OF_CHANNEL = 32,
  parameter int NUM_OF_WEIGHT  = 32,
  parameter int SHIFT_BITWIDTH = 5
);
  logic [NUM_OF_CHANNEL*DATA_BITWIDTH-1:0]               iacts;
  logic [NUM_OF_WEIGHT*NUM_OF_CHANNEL*DATA_BITWIDTH-1:0] wghts;
  logic                                                  tap_valid;
  logic                                                  tap_skip;
  logic                                                  tap_ready;
  logic [SHIFT_BITWIDTH-1:0]                             shift;
  logic                                                  relu_en;
  logic [NUM_OF_WEIGHT*DATA_BITWIDTH-1:0]                oacts;
  logic                                                  oacts_valid;
  logic                                                  oacts_ready;

  modport master (
    output iacts, wghts, tap_valid, tap_skip, shift, relu_en, oacts_ready,
    input  tap_ready, oacts, oacts_valid
  );

  modport slave (
    input  iacts, wghts, tap_valid, tap_skip, shift, relu_en, oacts_ready,
    output tap_ready, oacts, oacts_valid
  );
endinterface

// File: rtl/dilated_tap_mac_engine.sv
// Multi-tap MAC over KH*KW taps x NUM_OF_CHANNEL channels per filter, with
// per-tap skip, latched shift/ReLU requant and a registered valid/ready output.
module dtme_lane #(
  parameter int DW  = 8,
  parameter int NC  = 32,
  parameter int ACC = 25,
  parameter int SW  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NC*DW-1:0]     i_iacts,
  input  logic [NC*DW-1:0]     i_wghts,
  input  logic                 i_skip,
  input  logic                 i_acc_en,
  input  logic                 i_first,
  input  logic                 i_out_en,
  input  logic [SW-1:0]        i_shift,
  input  logic                 i_relu,
  output logic [DW-1:0]        o_oact
);
  // Wide enough that the rounding constant never falls off for any shift.
  localparam int RW = ACC + (1 << SW) + 1;
  localparam logic signed [RW-1:0] MAXV = (RW'(1) <<< (DW-1)) - RW'(1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic signed [ACC-1:0] r_acc, w_term, w_acc_nxt;
  logic        [RW-1:0]  w_rnd;
  logic signed [RW-1:0]  w_r;
  logic        [DW-1:0]  w_q, r_oact;

  // Modular ACC-bit sum equals the full-precision sum truncated to ACC bits.
  always_comb begin
    w_term = '0;
    if (!i_skip)
      for (int c = 0; c < NC; c++)
        w_term = w_term + ACC'($signed(i_iacts[(NC-1-c)*DW +: DW])) *
                          ACC'($signed(i_wghts[(NC-1-c)*DW +: DW]));
    w_acc_nxt = i_first ? w_term : r_acc + w_term;
  end

  always_comb begin
    w_rnd = (RW'(1) << i_shift) >> 1;
    w_r   = RW'(w_acc_nxt) + $signed(w_rnd);
    w_r   = w_r >>> i_shift;
    if (i_relu && w_r[RW-1]) w_r = '0;
    if (w_r > MAXV)      w_q = MAXV[DW-1:0];
    else if (w_r < MINV) w_q = MINV[DW-1:0];
    else                 w_q = w_r[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_oact <= '0;
    end else begin
      if (i_acc_en) r_acc  <= w_acc_nxt;
      if (i_out_en) r_oact <= w_q;
    end
  end

  assign o_oact = r_oact;
endmodule

module dilated_tap_mac_engine #(
  parameter int DATA_BITWIDTH  = 8,
  parameter int NUM_OF_CHANNEL = 32,
  parameter int NUM_OF_WEIGHT  = 32,
  parameter int KW             = 3,
  parameter int KH             = 3,
  parameter int ACC_BITWIDTH   = 25,
  parameter int SHIFT_BITWIDTH = 5
) (
  input logic                      clk,
  input logic                      rst,
  dilated_tap_mac_engine_if.slave  io_bus
);
  localparam int DW   = DATA_BITWIDTH;
  localparam int NC   = NUM_OF_CHANNEL;
  localparam int NW   = NUM_OF_WEIGHT;
  localparam int TAPS = KW * KH;
  localparam int CW   = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_tap_cnt;
  logic [SHIFT_BITWIDTH-1:0] r_shift;
  logic                      r_relu;
  logic                      r_oacts_valid;

  logic                      w_tap_ready, w_accept, w_first, w_last, w_done;
  logic [SHIFT_BITWIDTH-1:0] w_shift;
  logic                      w_relu;
  logic [NW-1:0][DW-1:0]     w_oacts;

  assign w_tap_ready = (r_state == S_ACC) | io_bus.oacts_ready;
  assign w_accept    = io_bus.tap_valid & w_tap_ready;
  assign w_first     = (r_tap_cnt == '0);
  assign w_last      = (r_tap_cnt == CW'(TAPS-1));
  assign w_done      = w_accept & w_last;
  // Tap 0 uses the live mode so a single-tap kernel still sees it.
  assign w_shift     = w_first ? io_bus.shift   : r_shift;
  assign w_relu      = w_first ? io_bus.relu_en : r_relu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_ACC;
      r_tap_cnt     <= '0;
      r_shift       <= '0;
      r_relu        <= 1'b0;
      r_oacts_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_first) begin
          r_shift <= io_bus.shift;
          r_relu  <= io_bus.relu_en;
        end
        r_tap_cnt <= w_last ? '0 : r_tap_cnt + CW'(1);
      end
      if (w_done) begin
        r_state       <= S_OUT;
        r_oacts_valid <= 1'b1;
      end else if (r_oacts_valid && io_bus.oacts_ready) begin
        r_state       <= S_ACC;
        r_oacts_valid <= 1'b0;
      end
    end
  end

  for (genvar o = 0; o < NW; o++) begin : g_lane
    dtme_lane #(.DW(DW), .NC(NC), .ACC(ACC_BITWIDTH), .SW(SHIFT_BITWIDTH)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_iacts  (io_bus.iacts),
      .i_wghts  (io_bus.wghts[(NW-1-o)*NC*DW +: NC*DW]),
      .i_skip   (io_bus.tap_skip),
      .i_acc_en (w_accept),
      .i_first  (w_first),
      .i_out_en (w_done),
      .i_shift  (w_shift),
      .i_relu   (w_relu),
      .o_oact   (w_oacts[o])
    );
  end

  assign io_bus.tap_ready   = w_tap_ready;
  assign io_bus.oacts       = w_oacts;
  assign io_bus.oacts_valid = r_oacts_valid;
endmodule

// File: doc/dilated_tap_mac_engine.md
Name: dilated_tap_mac_engine

Overview:
Parametrised successor of the bottleneck/ASPP layer datapath. It accumulates one output pixel over KH*KW kernel taps and NUM_OF_CHANNEL input channels for NUM_OF_WEIGHT output channels, then requantises the result to DATA_BITWIDTH.
It adds a valid/ready tap stream, per-tap skip for dilation holes and padding, and runtime shift/ReLU modes. Output is registered with a valid/ready handshake. It sits between the encoder-side tap/window fetcher and the ASPP concat stage.

Parameters:
DATA_BITWIDTH, 8, signed iact/weight/oact width
NUM_OF_CHANNEL, 32, input channels per tap
NUM_OF_WEIGHT, 32, output channels (filters)
KW, 3, kernel width (undilated)
KH, 3, kernel height (undilated)
ACC_BITWIDTH, 25, signed accumulator width; must be >= 2*DATA_BITWIDTH + clog2(KW*KH*NUM_OF_CHANNEL)
SHIFT_BITWIDTH, 5, width of the requant shift input

Ports:
clk  in  1  clock
rst  in  1  one clock; reset is synchronous and active-high
iacts  in  NUM_OF_CHANNEL*DATA_BITWIDTH  tap pixel, channel-packed; channel c at [(NUM_OF_CHANNEL-1-c)*DW +: DW] (channel 0 at MSB)
wghts  in  NUM_OF_WEIGHT*NUM_OF_CHANNEL*DATA_BITWIDTH  tap weights; (o,c) at [((NUM_OF_WEIGHT-1-o)*NUM_OF_CHANNEL + (NUM_OF_CHANNEL-1-c))*DW +: DW]
tap_valid  in  1  iacts/wghts/tap_skip valid
tap_skip  in  1  tap is consumed but contributes zero (dilation hole or padding)
tap_ready  out  1  engine accepts a tap this cycle
shift  in  SHIFT_BITWIDTH  requant arithmetic right shift
relu_en  in  1  clamp negatives to 0
oacts  out  NUM_OF_WEIGHT*DATA_BITWIDTH  result; filter o at [o*DW +: DW]
oacts_valid  out  1  oacts holds a complete pixel
oacts_ready  in  1  downstream consumes oacts

Behaviour:
- States:
  - ACC: accumulating; tap_ready=1.
  - OUT: result held; tap_ready=oacts_ready.
- Tap acceptance occurs when tap_valid & tap_ready.
- Reset, effective on the next clk edge: state=ACC, tap_cnt=0, all accumulators 0, oacts=0, oacts_valid=0, latched mode=0/0. Reset mid-pixel discards all partial sums.
- Mode latching: shift and relu_en are latched on acceptance of tap 0 of each pixel. Changes during taps 1..KH*KW-1 are ignored.
- Per accepted tap:
  - Each acc[o] += sum over c of signed(iact[c])*signed(wght[o][c]), in full precision, then truncated to ACC_BITWIDTH.
  - If tap_skip=1, the term is 0.
  - tap_cnt increments.
  - On tap 0, the accumulator is loaded with the term rather than added to it.
- On acceptance of tap KH*KW-1:
  - tap_cnt wraps to 0.
  - Requant is written to oacts and oacts_valid is set on the next edge. Latency is 1 cycle after the last tap.
  - state becomes OUT.
- Requant per filter, in this order:
  1. r = acc + (shift>0 ? 1<<(shift-1) : 0).
  2. r >>>= shift, arithmetic (floor).
  3. If relu_en, r = max(r,0).
  4. Saturate to [-2^(DW-1), 2^(DW-1)-1].
- OUT state:
  - oacts and oacts_valid are stable until oacts_valid & oacts_ready.
  - If oacts_ready=0: tap_ready=0; no taps are lost or consumed.
  - Consume without a new tap: oacts_valid drops next edge; state becomes ACC.
  - Consume with a simultaneous tap: the tap is accepted as tap 0 of the next pixel in that same cycle; oacts_valid drops unless that tap also completes a pixel (only when KH*KW=1, in which case new oacts load and valid stays 1).
- The engine never deasserts tap_ready in ACC. A continuous stream with oacts_ready tied high runs with zero bubbles.
- tap_valid=0 holds all state; tap_skip/iacts/wghts are don't-care then.
- oacts changes only on a completion edge or on reset.

Test Plan:
1. Defaults; all iacts=1, wghts=1, shift=0, relu_en=0, 9 taps -> every filter acc=288, oacts lane=127 (saturated), oacts_valid 1 cycle after tap 8.
2. Same data, shift=2 -> (288+2)>>2=72 every lane. Weights=-1, shift=2, relu_en=0 -> -72. Weights=-1, relu_en=1 -> 0.
3. iacts=2, wghts=3, taps 1,3,5,7 with tap_skip=1, shift=4 -> 5*32*6=960, (960+8)>>4=60 every lane. Shift changed to 0 during tap 4 -> still 60 (latched).
4. Backpressure: after completion hold oacts_ready=0 for 5 cycles while tap_valid=1 -> tap_ready=0, oacts stable. On release, tap accepted the same cycle as consume; next pixel correct.
5. Streaming: 27 consecutive valid taps with oacts_ready=1, per-filter distinct weights (filter o weight=o-16, iacts=1) -> three results, lane o = sat(288*(o-16)). tap_ready never low.
6. Assert rst for 1 cycle after 4 taps -> oacts_valid=0, oacts=0. The following 9 taps of test 1 data give 127 with no residue from the aborted pixel.
